fixed_math_arbiter: RTL and testbench
=====================================

Name: fixed_math_arbiter

Overview:
- Shares one fixed_inv_sqrt pipeline and one fixed_recip_lte1 pipeline among N requesters.
- Typical requesters: per-ray normalize and per-edge divide stages of the renderer.
- Grants at most one request per cycle using round-robin, and tags each operation through the pipelines.
- Aligns the two unit latencies and returns each result to its requester with a one-hot valid. Flags and saturates operands that are out of domain.

Parameters:
N, 4, number of requesters (2..8).
B, 20, fixed total width (the codebase fixed type; not overridable).
D, 8, fractional bits (the codebase fixed type; not overridable).

Ports:
clk_in  input  1  clock; all logic on posedge.
rst_n_in  input  1  asynchronous, active-low reset.
req_valid_in  input  N  request valid, one bit per requester.
req_op_in  input  N  per-requester op: 0 = inv_sqrt, 1 = recip.
req_data_in  input  N*B  per-requester operand (fixed); requester i uses bits [i*B +: B].
req_ready_out  output  N  one-hot grant; combinational from req_valid_in and the RR pointer.
resp_valid_out  output  N  one-hot, one-cycle result strobe to the owning requester.
resp_data_out  output  B  result (fixed), shared by all requesters.
resp_op_out  output  1  op of the returning result.
resp_err_out  output  1  operand was out of domain; resp_data_out = 0x7FFFF.
busy_out  output  1  high while any accepted op has not yet returned.

Behaviour:
- Reset: asynchronous assert, synchronous release.
  - Clears all tag/valid pipeline bits.
  - Forces resp_valid_out = 0, resp_err_out = 0, resp_op_out = 0, resp_data_out = 0, busy_out = 0.
  - Sets RR pointer last = N-1, so requester 0 has top priority first.
  - The datapath registers inside the math units are unreset; correctness relies only on the tag valids.
- Handshake:
  - Requester i is accepted on an edge where req_valid_in[i] && req_ready_out[i].
  - req_ready_out has at most one bit set. It is all-zero when no valid is present.
  - No dependency of ready on valid of the same requester beyond the RR search.
  - Requesters hold valid/op/data stable until accepted.
- Arbitration:
  - Search order is last+1, last+2, … (mod N). The first valid requester wins.
  - On accept, last := the winner. With no accept, last is unchanged.
- Throughput: one accept per cycle, sustained indefinitely. There is no back-pressure on responses; the requester must sink resp_valid_out.
- Pipeline (accept edge = k):
  - Stage 0 (edge k): register operand, op, one-hot id, err; valid=1. Drive both units with the registered operand every cycle.
  - Units: inv_sqrt latency 4. Recip latency 3 plus one delay register, giving 4.
  - Tag shift register depth 4 runs in parallel.
  - Output stage (edge k+5): select by op, register the result.
  - resp_valid_out goes high after edge k+6 and is held one cycle. Latency = 6 edges, fixed for both ops.
- Domain checks (on stage-0 operand x, combinational, registered with the tag):
  - inv_sqrt: err if x <= 0.
  - recip: err if x == 0, or |x| > 0x00100 (1.0), or |x| < 0x00004 (below LUT resolution).
  - On err: resp_data_out = 0x7FFFF and resp_err_out = 1. The unit output is discarded, and the op still occupies its slot and latency.
- Responses:
  - resp_data_out, resp_op_out and resp_err_out are meaningful only when |resp_valid_out.
  - When no response is valid, they hold their last value.
- Ordering: results return in acceptance order.
- busy_out: OR of the stage-0 valid, the tag-pipe valids and the output-stage valid.
- Reset mid-operation: in-flight ops are dropped. No response is ever issued for them after rst_n_in deasserts.
- Simultaneous events: an accept and a response for different ops in the same cycle are independent. The same requester may be accepted again while its earlier op is in flight.

Test Plan:
- Requester 0 sends inv_sqrt 0x00400 (4.0), others idle → ready[0] same cycle; resp_valid_out = 0001 exactly 6 edges later, data 0x00080 ±2 LSB, err = 0.
- Requester 2 sends recip 0x00080 (0.5), then recip 0xFFF80 (-0.5) back-to-back → two responses on consecutive cycles, 0x00200 then 0xFFE00 (±2 LSB), resp_op = 1, valid = 0100 both cycles.
- Out-of-domain operands:
  - inv_sqrt 0x00000 → err = 1, data 0x7FFFF.
  - inv_sqrt 0xFFF00 → err = 1, data 0x7FFFF.
  - recip 0x00180 → err = 1, data 0x7FFFF.
  - recip 0x00002 → err = 1, data 0x7FFFF.
  - All returned at latency 6 and in order.
- All 4 requesters hold valid for 8 cycles → grants in order 0,1,2,3,0,1,2,3; each requester gets exactly 2 responses; no idle cycle in the response stream.
- Accept 3 ops, assert rst_n_in low 2 cycles after the first accept → outputs clear immediately (asynchronously); no resp_valid_out for any of the 3 ops; next grant after release goes to requester 0.
- Random mixed ops, 1000 requests → every response matches a software model: one-hot id correct, latency 6, inv_sqrt within 0.5%, recip within 1%.

Source files
------------

// File: rtl/fixed_math_arbiter.sv
// Round-robin front end sharing one inverse-square-root and one reciprocal pipeline
// among N requesters; results return tagged, in acceptance order, at a fixed latency.

module fixed_inv_sqrt (
  input  logic        clk_in,
  input  logic [19:0] x_in,
  output logic [19:0] y_out
);
  // 1/sqrt(x/256) in Q.8 equals sqrt(2^32 / x) / 16, rounded.
  localparam logic [32:0] NUM = 33'h1_0000_0000;

  logic [18:0] den_reg;
  logic [32:0] quo_reg;
  logic [16:0] root_reg;
  logic [19:0] y_reg;

  function automatic logic [16:0] isqrt(input logic [33:0] v);
    logic [35:0] rem;
    logic [16:0] root;
    rem  = '0;
    root = '0;
    for (int i = 16; i >= 0; i--) begin
      rem = {rem[33:0], v[2*i+1 -: 2]};
      if (rem >= {17'b0, root, 2'b01}) begin
        rem  = rem - {17'b0, root, 2'b01};
        root = {root[15:0], 1'b1};
      end else begin
        root = {root[15:0], 1'b0};
      end
    end
    return root;
  endfunction

  // Non-positive operands are replaced by 1 so the divider never sees zero.
  always_ff @(posedge clk_in) begin
    den_reg  <= (x_in[19] || x_in == '0) ? 19'd1 : x_in[18:0];
    quo_reg  <= NUM / {14'b0, den_reg};
    root_reg <= isqrt({1'b0, quo_reg});
    y_reg    <= {7'b0, 13'((root_reg + 17'd8) >> 4)};
  end

  assign y_out = y_reg;
endmodule

module fixed_recip_lte1 (
  input  logic        clk_in,
  input  logic [19:0] x_in,
  output logic [19:0] y_out
);
  // 1/(x/256) in Q.8 equals 2^16 / x, rounded to nearest, sign restored last.
  logic        neg_reg;
  logic        neg2_reg;
  logic [8:0]  div_reg;
  logic [16:0] quo_reg;
  logic [19:0] y_reg;
  logic [19:0] mag;

  assign mag = x_in[19] ? (~x_in + 20'd1) : x_in;

  always_ff @(posedge clk_in) begin
    neg_reg  <= x_in[19];
    div_reg  <= (mag == '0 || mag > 20'd256) ? 9'd256 : mag[8:0];
    neg2_reg <= neg_reg;
    quo_reg  <= (17'h10000 + {9'b0, div_reg[8:1]}) / {8'b0, div_reg};
    y_reg    <= neg2_reg ? -{3'b0, quo_reg} : {3'b0, quo_reg};
  end

  assign y_out = y_reg;
endmodule

module fixed_math_arbiter #(
  parameter int N = 4,
  localparam int B = 20,
  localparam int D = 8
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  input  logic [N-1:0]   req_valid_in,
  input  logic [N-1:0]   req_op_in,
  input  logic [N*B-1:0] req_data_in,
  output logic [N-1:0]   req_ready_out,
  output logic [N-1:0]   resp_valid_out,
  output logic [B-1:0]   resp_data_out,
  output logic           resp_op_out,
  output logic           resp_err_out,
  output logic           busy_out
);
  localparam int PW    = $clog2(N);
  localparam int DEPTH = 4;
  localparam logic [B-1:0] SAT     = {1'b0, {(B-1){1'b1}}};
  localparam logic [B-1:0] ONE     = B'(1) << D;
  localparam logic [B-1:0] MIN_MAG = B'(1) << (D - 6);

  logic [B-1:0] req_data [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign req_data[gi] = req_data_in[gi*B +: B];
    end
  endgenerate

  logic [PW-1:0] last_reg;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] cand;
  logic          accept;

  always_comb begin
    req_ready_out = '0;
    win_idx       = last_reg;
    accept        = 1'b0;
    cand          = '0;
    for (int k = 1; k <= N; k++) begin
      cand = PW'((int'(last_reg) + k) % N);
      if (!accept && req_valid_in[cand]) begin
        accept                = 1'b1;
        win_idx               = cand;
        req_ready_out[cand]   = 1'b1;
      end
    end
  end

  logic         s0_valid_reg;
  logic         s0_op_reg;
  logic [N-1:0] s0_id_reg;
  logic [B-1:0] s0_data_reg;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      last_reg     <= PW'(N - 1);
      s0_valid_reg <= 1'b0;
      s0_op_reg    <= 1'b0;
      s0_id_reg    <= '0;
    end else begin
      s0_valid_reg <= accept;
      if (accept) begin
        last_reg  <= win_idx;
        s0_op_reg <= req_op_in[win_idx];
        s0_id_reg <= req_ready_out;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (accept) s0_data_reg <= req_data[win_idx];
  end

  logic [B-1:0] s0_mag;
  logic         s0_err;

  assign s0_mag = s0_data_reg[B-1] ? (~s0_data_reg + B'(1)) : s0_data_reg;

  // Reciprocal domain: 1/64 <= |x| <= 1.0 (zero falls below the lower bound).
  always_comb begin
    if (!s0_op_reg) s0_err = s0_data_reg[B-1] || (s0_data_reg == '0);
    else            s0_err = (s0_mag > ONE) || (s0_mag < MIN_MAG);
  end

  logic [DEPTH-1:0]        tag_valid_reg;
  logic [DEPTH-1:0]        tag_op_reg;
  logic [DEPTH-1:0]        tag_err_reg;
  logic [DEPTH-1:0][N-1:0] tag_id_reg;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tag_valid_reg <= '0;
      tag_op_reg    <= '0;
      tag_err_reg   <= '0;
      tag_id_reg    <= '0;
    end else begin
      tag_valid_reg <= {tag_valid_reg[DEPTH-2:0], s0_valid_reg};
      tag_op_reg    <= {tag_op_reg[DEPTH-2:0], s0_op_reg};
      tag_err_reg   <= {tag_err_reg[DEPTH-2:0], s0_err};
      tag_id_reg    <= {tag_id_reg[DEPTH-2:0], s0_id_reg};
    end
  end

  logic [B-1:0] isq_y;
  logic [B-1:0] rcp_y;
  logic [B-1:0] rcp_dly_reg;

  fixed_inv_sqrt u_isq (
    .clk_in (clk_in),
    .x_in   (s0_data_reg),
    .y_out  (isq_y)
  );

  fixed_recip_lte1 u_rcp (
    .clk_in (clk_in),
    .x_in   (s0_data_reg),
    .y_out  (rcp_y)
  );

  // Pads the 3-cycle reciprocal up to the 4-cycle inverse square root.
  always_ff @(posedge clk_in) rcp_dly_reg <= rcp_y;

  logic         out_valid_reg;
  logic         out_op_reg;
  logic         out_err_reg;
  logic [N-1:0] out_id_reg;
  logic [B-1:0] out_data_reg;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      out_valid_reg <= 1'b0;
      out_op_reg    <= 1'b0;
      out_err_reg   <= 1'b0;
      out_id_reg    <= '0;
    end else begin
      out_valid_reg <= tag_valid_reg[DEPTH-1];
      out_op_reg    <= tag_op_reg[DEPTH-1];
      out_err_reg   <= tag_err_reg[DEPTH-1];
      out_id_reg    <= tag_id_reg[DEPTH-1];
    end
  end

  always_ff @(posedge clk_in) begin
    out_data_reg <= tag_err_reg[DEPTH-1] ? SAT : (tag_op_reg[DEPTH-1] ? rcp_dly_reg : isq_y);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      resp_valid_out <= '0;
      resp_data_out  <= '0;
      resp_op_out    <= 1'b0;
      resp_err_out   <= 1'b0;
    end else begin
      resp_valid_out <= out_valid_reg ? out_id_reg : '0;
      if (out_valid_reg) begin
        resp_data_out <= out_data_reg;
        resp_op_out   <= out_op_reg;
        resp_err_out  <= out_err_reg;
      end
    end
  end

  assign busy_out = s0_valid_reg | (|tag_valid_reg) | out_valid_reg;
endmodule

// File: tb/tb_fixed_math_arbiter.sv
// Randomised and directed bench for fixed_math_arbiter against a real-arithmetic model
// with a round-robin grant predictor and an in-order response scoreboard.

module tb_fixed_math_arbiter;
  localparam int N = 4;
  localparam int B = 20;

  logic           clk_in = 1'b0;
  logic           rst_n_in = 1'b0;
  logic [N-1:0]   req_valid_in = '0;
  logic [N-1:0]   req_op_in = '0;
  logic [N*B-1:0] req_data_in = '0;
  logic [N-1:0]   req_ready_out;
  logic [N-1:0]   resp_valid_out;
  logic [B-1:0]   resp_data_out;
  logic           resp_op_out;
  logic           resp_err_out;
  logic           busy_out;

  fixed_math_arbiter #(.N(N)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .req_valid_in   (req_valid_in),
    .req_op_in      (req_op_in),
    .req_data_in    (req_data_in),
    .req_ready_out  (req_ready_out),
    .resp_valid_out (resp_valid_out),
    .resp_data_out  (resp_data_out),
    .resp_op_out    (resp_op_out),
    .resp_err_out   (resp_err_out),
    .busy_out       (busy_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct { int rq; bit op; logic [B-1:0] data; } req_t;
  typedef struct { int id; int op; int err; int val; int tol; int due; } exp_t;

  req_t        script_q[$];
  exp_t        exp_q[$];
  bit          pend_v[N];
  bit          pend_op[N];
  logic [B-1:0] pend_data[N];
  int          last_rr = N - 1;
  int          grant_log[$];
  int          resp_cnt[N];
  int          gap_pct = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input int got, input int exp, input int tol = 0);
    int diff;
    checks++;
    diff = got - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h tol=%0d cyc=%0d", tag, got, exp, tol, cyc);
    end
  endtask

  // Reference: plain real arithmetic on the operand value.
  function automatic void model(input int op, input logic [B-1:0] x,
                                output int err, output int val, output int tol);
    int  xi;
    real xv, ax, r;
    xi  = {{12{x[B-1]}}, x};
    xv  = $itor(xi) / 256.0;
    ax  = (xv < 0.0) ? -xv : xv;
    err = 0;
    r   = 0.0;
    if (op == 0) begin
      if (xv <= 0.0) err = 1; else r = 1.0 / $sqrt(xv);
    end else begin
      if (ax > 1.0 || ax < 4.0 / 256.0) err = 1; else r = 1.0 / xv;
    end
    if (err != 0) begin
      val = 'h7FFFF;
      tol = 0;
    end else begin
      val = $rtoi(r * 256.0 + ((r < 0.0) ? -0.5 : 0.5));
      tol = $rtoi(((op == 0) ? 0.005 : 0.01) * $itor((val < 0) ? -val : val));
      if (tol < 2) tol = 2;
    end
  endfunction

  function automatic req_t rand_req(input int rq);
    req_t r;
    int   sh, mag;
    r.rq = rq;
    r.op = 1'($urandom_range(1, 0));
    if ($urandom_range(9, 0) < 8) begin
      if (r.op == 1'b0) begin
        sh     = $urandom_range(18, 0);
        r.data = 20'($urandom_range((1 << (sh + 1)) - 1, 1));
      end else begin
        mag    = $urandom_range(256, 4);
        r.data = ($urandom_range(1, 0) != 0) ? 20'(-mag) : 20'(mag);
      end
    end else begin
      if (r.op == 1'b0) begin
        r.data = ($urandom_range(1, 0) != 0) ? 20'h0 : (20'($urandom_range('h7FFFF, 0)) | 20'h80000);
      end else begin
        mag    = ($urandom_range(1, 0) != 0) ? $urandom_range(3, 0) : $urandom_range('h7FFFF, 257);
        r.data = ($urandom_range(1, 0) != 0) ? 20'(-mag) : 20'(mag);
      end
    end
    return r;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (!pend_v[i] && $urandom_range(99, 0) >= gap_pct) begin
        for (int j = 0; j < script_q.size(); j++) begin
          if (script_q[j].rq == i) begin
            pend_v[i]    = 1'b1;
            pend_op[i]   = script_q[j].op;
            pend_data[i] = script_q[j].data;
            script_q.delete(j);
            break;
          end
        end
      end
      req_valid_in[i]        = pend_v[i];
      req_op_in[i]           = pend_op[i];
      req_data_in[i*B +: B]  = pend_data[i];
    end
  endtask

  // One clock: predict the grant, check ready, log the expected response.
  task automatic cycle();
    int           win;
    exp_t         e;
    logic [N-1:0] er;
    @(negedge clk_in);
    win = -1;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last_rr + k) % N;
      if (win < 0 && pend_v[idx]) win = idx;
    end
    er = '0;
    if (win >= 0) er[win] = 1'b1;
    check("ready", int'(req_ready_out), int'(er));
    if (win >= 0) begin
      model(int'(pend_op[win]), pend_data[win], e.err, e.val, e.tol);
      e.id  = win;
      e.op  = int'(pend_op[win]);
      e.due = cyc + 7;
      exp_q.push_back(e);
      last_rr     = win;
      pend_v[win] = 1'b0;
      grant_log.push_back(win);
    end
    @(posedge clk_in);
    #1;
    drive();
  endtask

  task automatic drain(input int budget);
    int  n;
    bit  any;
    n = 0;
    forever begin
      any = 1'b0;
      foreach (pend_v[i]) if (pend_v[i]) any = 1'b1;
      if (!(any || exp_q.size() > 0 || script_q.size() > 0) || n >= budget) break;
      cycle();
      n++;
    end
    if (n >= budget) check("drain_timeout", n, 0);
    repeat (3) cycle();
  endtask

  // Response monitor: in-order scoreboard, latency, id, op, err, data, busy.
  initial begin
    exp_t e;
    int   busy_exp;
    int   got;
    forever begin
      @(negedge clk_in);
      if (rst_n_in) begin
        busy_exp = 0;
        foreach (exp_q[i]) if (exp_q[i].due - 6 <= cyc && exp_q[i].due > cyc) busy_exp = 1;
        check("busy", int'(busy_out), busy_exp);
        if (|resp_valid_out) begin
          if (exp_q.size() == 0) begin
            check("spurious_resp", int'(resp_valid_out), 0);
          end else begin
            e   = exp_q.pop_front();
            got = {{12{resp_data_out[B-1]}}, resp_data_out};
            check("latency", cyc, e.due);
            check("resp_id", int'(resp_valid_out), 1 << e.id);
            check("resp_op", int'(resp_op_out), e.op);
            check("resp_err", int'(resp_err_out), e.err);
            check("resp_data", got, e.val, e.tol);
            resp_cnt[e.id]++;
            $display("resp cyc=%0d id=%0d op=%0d err=%0d data=%05h exp=%05h",
                     cyc, e.id, e.op, resp_err_out, resp_data_out, e.val & 'hFFFFF);
          end
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          e = exp_q.pop_front();
          check("missing_resp", 0, 1);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    req_t r;
    foreach (pend_v[i]) begin
      pend_v[i]    = 1'b0;
      pend_op[i]   = 1'b0;
      pend_data[i] = '0;
    end
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_resp_valid", int'(resp_valid_out), 0);
    check("rst_busy", int'(busy_out), 0);
    check("rst_resp_data", int'(resp_data_out), 0);
    check("rst_resp_err", int'(resp_err_out), 0);
    check("rst_resp_op", int'(resp_op_out), 0);
    check("rst_ready_idle", int'(req_ready_out), 0);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;

    // Single inv_sqrt of 4.0 from requester 0.
    script_q.push_back('{0, 1'b0, 20'h00400});
    drive();
    drain(50);

    // Back-to-back reciprocals of +0.5 and -0.5 from requester 2.
    script_q.push_back('{2, 1'b1, 20'h00080});
    script_q.push_back('{2, 1'b1, 20'hFFF80});
    drive();
    drain(50);

    // Out-of-domain operands from requester 3.
    script_q.push_back('{3, 1'b0, 20'h00000});
    script_q.push_back('{3, 1'b0, 20'hFFF00});
    script_q.push_back('{3, 1'b1, 20'h00180});
    script_q.push_back('{3, 1'b1, 20'h00002});
    drive();
    drain(50);

    // All requesters held valid: strict rotation, two responses each.
    grant_log.delete();
    foreach (resp_cnt[i]) resp_cnt[i] = 0;
    for (int rep = 0; rep < 2; rep++)
      for (int i = 0; i < N; i++) script_q.push_back(rand_req(i));
    drive();
    drain(50);
    check("rr_grant_count", grant_log.size(), 2 * N);
    for (int j = 0; j < 2 * N; j++)
      if (j < grant_log.size()) check("rr_grant_order", grant_log[j], j % N);
    for (int i = 0; i < N; i++) check("rr_resp_count", resp_cnt[i], 2);

    // Reset with three ops in flight.
    script_q.push_back('{1, 1'b0, 20'h00100});
    script_q.push_back('{2, 1'b1, 20'h00080});
    script_q.push_back('{3, 1'b0, 20'h00200});
    drive();
    repeat (3) cycle();
    #2;
    rst_n_in = 1'b0;
    #1;
    check("async_rst_busy", int'(busy_out), 0);
    check("async_rst_valid", int'(resp_valid_out), 0);
    check("async_rst_data", int'(resp_data_out), 0);
    check("async_rst_err", int'(resp_err_out), 0);
    exp_q.delete();
    script_q.delete();
    foreach (pend_v[i]) pend_v[i] = 1'b0;
    last_rr = N - 1;
    drive();
    repeat (2) @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    repeat (10) cycle();
    grant_log.delete();
    for (int i = N - 1; i >= 0; i--) script_q.push_back(rand_req(i));
    drive();
    cycle();
    check("post_rst_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
    drain(50);

    // Randomised mixed traffic.
    gap_pct = 30;
    for (int n = 0; n < 1000; n++) begin
      r = rand_req($urandom_range(N - 1, 0));
      script_q.push_back(r);
    end
    drive();
    drain(20000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
